instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue.sv | 110 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetches FETCH_W words per cycle from an internal nop ROM
// and presents up to ISSUE_W head instructions. Optional redirect port under IFQ_REDIRECT_EN.
module instruction_fetch_queue #(
    parameter int ISSUE_W = 2,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int MEM_AW  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(ISSUE_W+1)-1:0]  shift_count,
`ifdef IFQ_REDIRECT_EN
    input  logic                          redirect_valid,
    input  logic [MEM_AW-1:0]             redirect_pc,
`endif
    output logic [ISSUE_W*32-1:0]         instr,
    output logic [ISSUE_W*MEM_AW-1:0]     instr_pc,
    output logic [ISSUE_W-1:0]            instr_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FETCH_C = CW'(FETCH_W);
    localparam logic [CW-1:0] ISSUE_C = CW'(ISSUE_W);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [MEM_AW-1:0] pc_reg, pc_next;
    logic [PW-1:0]     head_reg, head_next;
    logic [PW-1:0]     tail_reg, tail_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [CW-1:0]     free_slots;
    logic [CW-1:0]     pop;
    logic              fetch_en;

    logic [31:0]       rom [2**MEM_AW];
    logic [31:0]       slot_instr_reg [DEPTH];
    logic [MEM_AW-1:0] slot_pc_reg [DEPTH];

    // Read-only instruction memory: every word holds a nop and there is no write port.
    genvar gi;
    generate
        for (gi = 0; gi < 2**MEM_AW; gi++) begin : g_rom
            assign rom[gi] = NOP;
        end
    endgenerate

    always_comb begin
        free_slots = DEPTH_C - count_reg;
        fetch_en   = (free_slots >= FETCH_C);
        pop        = CW'(shift_count);
        if (pop > count_reg) pop = count_reg;
        if (pop > ISSUE_C)   pop = ISSUE_C;
`ifdef IFQ_REDIRECT_EN
        if (redirect_valid) begin
            fetch_en = 1'b0;
            pop      = '0;
        end
`endif
        pc_next    = fetch_en ? pc_reg + MEM_AW'(FETCH_W) : pc_reg;
        head_next  = head_reg + pop[PW-1:0];
        tail_next  = fetch_en ? tail_reg + PW'(FETCH_W) : tail_reg;
        count_next = count_reg - pop + (fetch_en ? FETCH_C : '0);
`ifdef IFQ_REDIRECT_EN
        // A redirect flushes the queue; fetching from the new pc starts next cycle.
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            head_next  = tail_reg;
            count_next = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Slot storage needs no reset: only slots below count are ever presented.
    always_ff @(posedge clk) begin
        if (!reset && fetch_en) begin
            for (int k = 0; k < FETCH_W; k++) begin
                slot_instr_reg[tail_reg + PW'(k)] <= rom[pc_reg + MEM_AW'(k)];
                slot_pc_reg[tail_reg + PW'(k)]    <= pc_reg + MEM_AW'(k);
            end
        end
    end

    generate
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_lane
            logic [PW-1:0] rd_idx;
            logic          lane_ok;
            assign rd_idx  = head_reg + PW'(gi);
            assign lane_ok = !reset && (count_reg > CW'(gi));
            assign instr_valid[gi]               = lane_ok;
            assign instr[32*gi +: 32]            = lane_ok ? slot_instr_reg[rd_idx] : NOP;
            assign instr_pc[MEM_AW*gi +: MEM_AW] = lane_ok ? slot_pc_reg[rd_idx] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue: a queue-based reference model predicts
// the lane outputs after every edge; a monitor compares them one cycle at a time.
module tb_instruction_fetch_queue;

    localparam int ISSUE_W = 2;
    localparam int FETCH_W = 2;
    localparam int DEPTH   = 8;
    localparam int MEM_AW  = 8;
    localparam int SCW     = $clog2(ISSUE_W+1);
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFQ_REDIRECT_EN
    localparam bit RED_EN = 1'b1;
`else
    localparam bit RED_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [SCW-1:0]            shift_count = '0;
    logic [ISSUE_W*32-1:0]     instr;
    logic [ISSUE_W*MEM_AW-1:0] instr_pc;
    logic [ISSUE_W-1:0]        instr_valid;
`ifdef IFQ_REDIRECT_EN
    logic                      redirect_valid = 1'b0;
    logic [MEM_AW-1:0]         redirect_pc = '0;
`endif

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .ISSUE_W(ISSUE_W), .FETCH_W(FETCH_W), .DEPTH(DEPTH), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .shift_count(shift_count),
`ifdef IFQ_REDIRECT_EN
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
`endif
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid)
    );

    typedef struct {
        logic [ISSUE_W-1:0]        v;
        logic [ISSUE_W*MEM_AW-1:0] pc;
        logic [ISSUE_W*32-1:0]     ins;
        int                        cyc;
    } exp_t;

    exp_t sb[$];
    int   mq[$];      // model queue of fetched word addresses, oldest first
    int   mpc = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Drive one cycle of stimulus, advance the model past the coming edge, queue the expectation.
    task automatic apply(input bit rst, input int sc, input bit redir, input int rpc);
        exp_t e;
        int   n;
        bit   can_fetch;
        reset       = rst;
        shift_count = SCW'(sc);
`ifdef IFQ_REDIRECT_EN
        redirect_valid = redir;
        redirect_pc    = MEM_AW'(rpc);
`endif
        if (rst) begin
            mq.delete();
            mpc = 0;
        end else if (redir && RED_EN) begin
            mq.delete();
            mpc = rpc % (2**MEM_AW);
        end else begin
            can_fetch = (DEPTH - mq.size()) >= FETCH_W;
            n = sc;
            if (n > mq.size()) n = mq.size();
            if (n > ISSUE_W) n = ISSUE_W;
            repeat (n) void'(mq.pop_front());
            if (can_fetch) begin
                for (int k = 0; k < FETCH_W; k++) mq.push_back((mpc + k) % (2**MEM_AW));
                mpc = (mpc + FETCH_W) % (2**MEM_AW);
            end
        end
        e.v   = '0;
        e.pc  = '0;
        e.ins = {ISSUE_W{NOP}};
        e.cyc = cyc;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (i < mq.size()) begin
                e.v[i] = 1'b1;
                e.pc[MEM_AW*i +: MEM_AW] = MEM_AW'(mq[i]);
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Monitor: compare post-edge outputs, then check output gating while reset is held.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty cycle=%0d: output present with no expectation", cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (instr_valid !== e.v) begin
                    bad++;
                    $display("FAIL instr_valid cycle=%0d got=%b want=%b", e.cyc, instr_valid, e.v);
                end
                total++;
                if (instr_pc !== e.pc) begin
                    bad++;
                    $display("FAIL instr_pc cycle=%0d got=%h want=%h", e.cyc, instr_pc, e.pc);
                end
                total++;
                if (instr !== e.ins) begin
                    bad++;
                    $display("FAIL instr cycle=%0d got=%h want=%h", e.cyc, instr, e.ins);
                end
                $display("cyc=%0d valid=%b pc=%h", e.cyc, instr_valid, instr_pc);
            end
            #3;
            if (reset) begin
                total++;
                if (instr_valid !== '0 || instr_pc !== '0 || instr !== {ISSUE_W{NOP}}) begin
                    bad++;
                    $display("FAIL reset_gate cycle=%0d got valid=%b pc=%h want valid=0 pc=0", cyc, instr_valid, instr_pc);
                end
            end
        end
    end

    initial begin
        int sc;
        bit rst;
        bit redir;
        // Reset, then fill with no consumption until fetch stalls at a full queue.
        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        repeat (6) apply(0, 0, 0, 0);
        // Drain two from a full queue; fetch resumes the cycle after.
        apply(0, 2, 0, 0);
        apply(0, 0, 0, 0);
        // Steady consumption long enough to wrap the 8-bit pc through 254,255,0,1.
        repeat (140) apply(0, 2, 0, 0);
        if (RED_EN) begin
            apply(0, 2, 1, 'h40);
            apply(0, 0, 0, 0);
            apply(0, 0, 0, 0);
            repeat (3) apply(0, 1, 0, 0);
            apply(1, 1, 1, 'h77);
            repeat (3) apply(0, 1, 0, 0);
        end
        // Mid-operation reset discards everything.
        apply(1, 2, 0, 0);
        repeat (3) apply(0, 0, 0, 0);
        repeat (400) begin
            sc    = $urandom_range(0, 3);
            rst   = ($urandom_range(0, 39) == 0);
            redir = RED_EN && ($urandom_range(0, 14) == 0);
            apply(rst, sc, redir, $urandom_range(0, 255));
        end
        apply(0, 0, 0, 0);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
